avm_arbiter_2to1: RTL

- Two-master to one-slave Avalon-MM arbiter.
- Sits directly downstream of the ray tracer's SDRAM loader/writer (port s0) and the triangle fetcher (port s1).
- Drives the single 16-bit SDRAM controller port.
- Replaces bitwise OR-merging of the masters: grants one master per transaction and routes pipelined read responses back to the master that issued each read.

---
 rtl/avm_pkg.sv | 24 ++
 rtl/avm_id_fifo.sv | 67 ++++++
 rtl/avm_arbiter_2to1.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/avm_pkg.sv
// Shared Avalon-MM widths, master identifiers and arbiter state type.
package avm_pkg;

    localparam int unsigned AVM_AW  = 32;
    localparam int unsigned AVM_DW  = 16;
    localparam int unsigned AVM_BEW = 2;

    // Master identifier carried through the read-tracking FIFO.
    typedef logic avm_id_t;

    localparam avm_id_t AVM_ID_S0 = 1'b0;
    localparam avm_id_t AVM_ID_S1 = 1'b1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    // The master that is not 'id'; used for the round-robin hand-over.
    function automatic avm_id_t avm_other(input avm_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/avm_id_fifo.sv
// Read-owner FIFO: one ID per read accepted by the controller, popped in
// order as read responses come back.
module avm_id_fifo
    import avm_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  avm_id_t          din,
    output avm_id_t          dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    avm_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Status flags and qualified push/pop. A push while full is only taken
    // when a pop frees the slot in the same cycle; a pop while empty is only
    // taken when it consumes the entry being pushed (head bypass below).
    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        do_push = push & (~full | pop);
        do_pop  = pop & (~empty | push);
        dout    = empty ? din : mem[rd_ptr];
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/avm_arbiter_2to1.sv
// Two-master to one-slave Avalon-MM arbiter for the SDRAM controller port.
// Commands pass through combinationally; read responses are steered back to
// the issuing master using an in-order ID FIFO.
module avm_arbiter_2to1
    import avm_pkg::*;
#(
    parameter int unsigned MAX_PENDING = 8,
    parameter int unsigned S0_PRIORITY = 0
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               s0_read,
    input  logic               s0_write,
    input  logic [AVM_AW-1:0]  s0_address,
    input  logic [AVM_DW-1:0]  s0_writedata,
    input  logic [AVM_BEW-1:0] s0_byteenable,
    output logic               s0_waitrequest,
    output logic [AVM_DW-1:0]  s0_readdata,
    output logic               s0_readdatavalid,

    input  logic               s1_read,
    input  logic               s1_write,
    input  logic [AVM_AW-1:0]  s1_address,
    input  logic [AVM_DW-1:0]  s1_writedata,
    input  logic [AVM_BEW-1:0] s1_byteenable,
    output logic               s1_waitrequest,
    output logic [AVM_DW-1:0]  s1_readdata,
    output logic               s1_readdatavalid,

    output logic               m_read,
    output logic               m_write,
    output logic [AVM_AW-1:0]  m_address,
    output logic [AVM_DW-1:0]  m_writedata,
    output logic [AVM_BEW-1:0] m_byteenable,
    input  logic               m_waitrequest,
    input  logic [AVM_DW-1:0]  m_readdata,
    input  logic               m_readdatavalid,

    output logic               err_orphan
);

    localparam int unsigned FIFO_CNT_W = $clog2(MAX_PENDING + 1);

    arb_state_t            state_q, state_d;
    avm_id_t               owner_q, owner_d;
    avm_id_t               rr_q, rr_d;      // master preferred on next contention
    logic                  gnt_valid;
    avm_id_t               gnt_id;

    logic                  fifo_push;
    logic                  fifo_pop;
    avm_id_t               fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;

    logic                  pop_live;
    logic                  read_room;
    logic                  cand0, cand1;
    logic                  has_head;

    // Candidate qualification: a read needs a free FIFO slot, or a slot
    // being freed by a response this very cycle.
    always_comb begin
        pop_live  = m_readdatavalid & (fifo_count != '0);
        read_room = ~fifo_full | pop_live;
        cand0     = s0_write | (s0_read & read_room);
        cand1     = s1_write | (s1_read & read_room);
    end

    // Next-state, grant selection and round-robin pointer update.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        gnt_valid = 1'b0;
        gnt_id    = AVM_ID_S0;
        case (state_q)
            ARB_IDLE: begin
                if (cand0 | cand1) begin
                    gnt_valid = 1'b1;
                    if (cand0 & cand1) begin
                        gnt_id = (S0_PRIORITY != 0) ? AVM_ID_S0 : rr_q;
                    end else begin
                        gnt_id = cand1 ? AVM_ID_S1 : AVM_ID_S0;
                    end
                    if (m_waitrequest) begin
                        state_d = ARB_HOLD;
                        owner_d = gnt_id;
                    end else begin
                        rr_d = avm_other(gnt_id);
                    end
                end
            end
            ARB_HOLD: begin
                gnt_valid = 1'b1;
                gnt_id    = owner_q;
                if (!m_waitrequest) begin
                    state_d = ARB_IDLE;
                    rr_d    = avm_other(owner_q);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Arbiter state, owner and pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= AVM_ID_S0;
            rr_q    <= AVM_ID_S0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    // Command mux: forward the granted master, zero everything otherwise.
    always_comb begin
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_address    = '0;
        m_writedata  = '0;
        m_byteenable = '0;
        if (gnt_valid && !reset) begin
            if (gnt_id == AVM_ID_S1) begin
                m_read       = s1_read;
                m_write      = s1_write;
                m_address    = s1_address;
                m_writedata  = s1_writedata;
                m_byteenable = s1_byteenable;
            end else begin
                m_read       = s0_read;
                m_write      = s0_write;
                m_address    = s0_address;
                m_writedata  = s0_writedata;
                m_byteenable = s0_byteenable;
            end
        end
    end

    // Stall routing: the granted master sees the controller, the other is
    // held off; with no grant only a blocked (ineligible) request stalls.
    always_comb begin
        s0_waitrequest = 1'b1;
        s1_waitrequest = 1'b1;
        if (!reset) begin
            if (gnt_valid) begin
                s0_waitrequest = (gnt_id == AVM_ID_S0) ? m_waitrequest : 1'b1;
                s1_waitrequest = (gnt_id == AVM_ID_S1) ? m_waitrequest : 1'b1;
            end else begin
                s0_waitrequest = s0_read | s0_write;
                s1_waitrequest = s1_read | s1_write;
            end
        end
    end

    // Read tracking: push the owner on each accepted read, pop per response.
    always_comb begin
        fifo_push = m_read & ~m_waitrequest;
        fifo_pop  = m_readdatavalid & ~reset;
        has_head  = ~fifo_empty | fifo_push;
    end

    avm_id_fifo #(
        .DEPTH (MAX_PENDING),
        .CNT_W (FIFO_CNT_W)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (gnt_id),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Response routing: data is broadcast, valid goes only to the head owner.
    always_comb begin
        s0_readdata      = m_readdata;
        s1_readdata      = m_readdata;
        s0_readdatavalid = ~reset & m_readdatavalid & has_head & (fifo_dout == AVM_ID_S0);
        s1_readdatavalid = ~reset & m_readdatavalid & has_head & (fifo_dout == AVM_ID_S1);
    end

    // Sticky flag for a response that no outstanding read accounts for.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_orphan <= 1'b0;
        end else if (m_readdatavalid && !has_head) begin
            err_orphan <= 1'b1;
        end
    end

endmodule
